arb2x1_reg: RTL and testbench
=============================

# arb2x1_reg

Two-input round-robin arbiter with a registered output stage, sitting directly upstream of the datapath's consumers. It selects one of two valid/ready operand streams through an internal `mux2x1` and holds the result in a one-entry output register with valid/ready flow control. It also drives the select for that mux from its own priority state.

## Interface
- `DATAWIDTH`, default 64: width of both operands and the output.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `a`  in  DATAWIDTH  operand stream A data.
- `a_valid`  in  1  A data present.
- `a_ready`  out  1  A transfer accepted this cycle.
- `b`  in  DATAWIDTH  operand stream B data.
- `b_valid`  in  1  B data present.
- `b_ready`  out  1  B transfer accepted this cycle.
- `d`  out  DATAWIDTH  registered selected data.
- `d_src`  out  1  source of `d`: 0 = A, 1 = B.
- `d_valid`  out  1  `d` holds an unconsumed result.
- `d_ready`  in  1  downstream accepts `d` this cycle.

## Operation
- Transfer on an input: `x_valid && x_ready` at a rising edge. Output transfer: `d_valid && d_ready`.
- Priority pointer `pri`, two states:
  - PRI_A: A wins a tie.
  - PRI_B: B wins a tie.
- Grant (combinational):
  - Only A valid → A.
  - Only B valid → B.
  - Both valid → side named by `pri`.
  - Neither valid → no grant.
- `grant` drives the `mux2x1` `sel` (0 = A, 1 = B).
- `load = (a_valid || b_valid) && (!d_valid || d_ready)`. Ready is asserted only to the granted side, and only when `load` is 1. The non-granted side's ready is 0.
- On `load`:
  - `d` ← mux output, `d_src` ← grant, `d_valid` ← 1.
  - `pri` ← the side opposite the grant. This applies even when only one input was valid.
- Output transfer with no `load` → `d_valid` ← 0. `d` and `d_src` keep their last values.
- `pri` changes only on `load`; cycles with no input transfer leave it unchanged.
- Upstream holds `x` and `x_valid` stable while `x_valid && !x_ready`. Valid never depends on ready, in either direction.
- Backpressure (`d_valid && !d_ready`): both readies are 0, and `d`, `d_src`, `d_valid` and `pri` hold.

## Timing
- Reset values: `d` = 0, `d_src` = 0, `d_valid` = 0, `pri` = PRI_A, `a_ready` = 0, `b_ready` = 0 (the readies are 0 because `load` is 0).
- Reset asserted mid-operation clears all state immediately. The held result is discarded and no transfer completes in that cycle.
- Latency: an input accepted at edge N appears as `d` with `d_valid` = 1 after edge N.
- Throughput: one result per cycle when `d_ready` stays 1. Both inputs continuously valid alternate A, B, A, B.
- Readies are combinational from `a_valid`, `b_valid`, `d_valid`, `d_ready` and `pri`. There is no combinational path from `a` or `b` data to any control output.
- Simultaneous output drain and input accept in one cycle: the register reloads; `d_valid` stays 1 with no bubble.

## Structure
- Localparams `PRI_A` = 1'b0 and `PRI_B` = 1'b1 belong in the shared datapath constants include alongside the other component encodings.
- One sub-module: `mux2x1 #(.DATAWIDTH(DATAWIDTH))`, with inputs `a`, `b`, `sel` = grant and output feeding the `d` register.
- Arbitration logic, the `pri` register and the output register live in `arb2x1_reg` itself.

## Test plan
- Reset, then idle with no valids → `d_valid` = 0, `d` = 0, both readies 0, `pri` = PRI_A; assert `Rst` mid-stream later → `d_valid` drops to 0 without waiting for an edge.
- A only, `a` = 64'h5, `d_ready` = 1 → `a_ready` = 1; next cycle `d` = 5, `d_src` = 0, `d_valid` = 1; `pri` = PRI_B.
- Both valid continuously, `a` = 64'h11, `b` = 64'h22, `d_ready` = 1 → outputs 11, 22, 11, 22 … with `d_src` toggling 0, 1, 0, 1.
- Both valid, `d_ready` held 0 for 3 cycles after the first result → `d` holds, both readies 0, `pri` unchanged; release → next grant goes to the opposite side.
- `DATAWIDTH` = 8, `a` = 8'hFF, `b` = 8'h00 alternating with random `d_ready` → every accepted input appears exactly once in order, no drops or duplicates, and no bubble whenever `d_ready` = 1.

Source files
------------

// File: rtl/arb2x1_reg_pkg.sv
// Shared datapath constants for the two-input arbiter and its consumers.
// The priority pointer encoding doubles as the mux select encoding (0 = A, 1 = B).
package arb2x1_reg_pkg;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/arb2x1_reg_mux2x1.sv
// Plain two-way operand selector; sel = 0 passes a, sel = 1 passes b.
module mux2x1 #(
    parameter int DATAWIDTH = 64
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sel,
    output logic [DATAWIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/arb2x1_reg.sv
// Two-input round-robin arbiter feeding a one-entry registered output stage.
// The priority pointer flips away from whichever side was just loaded.
module arb2x1_reg
    import arb2x1_reg_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_src,
    output logic                 d_valid,
    input  logic                 d_ready
);

    pri_e                 pri;
    pri_e                 pri_next;
    logic                 grant;
    logic                 load;
    logic [DATAWIDTH-1:0] mux_out;

    mux2x1 #(.DATAWIDTH(DATAWIDTH)) u_mux (
        .a   (a),
        .b   (b),
        .sel (grant),
        .y   (mux_out)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pri <= PRI_A;
        end else begin
            pri <= pri_next;
        end
    end

    // A load always hands the next tie to the side that just lost or was absent.
    always_comb begin
        pri_next = pri;
        if (load) begin
            pri_next = (grant == SRC_B) ? PRI_A : PRI_B;
        end
    end

    // Only valids, the pointer and the output register state steer control; data never does.
    always_comb begin
        grant = SRC_A;
        if (a_valid && b_valid) begin
            grant = (pri == PRI_B) ? SRC_B : SRC_A;
        end else if (b_valid) begin
            grant = SRC_B;
        end
        load    = (a_valid || b_valid) && (!d_valid || d_ready);
        a_ready = load && (grant == SRC_A);
        b_ready = load && (grant == SRC_B);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            d       <= '0;
            d_src   <= SRC_A;
            d_valid <= 1'b0;
        end else if (load) begin
            d       <= mux_out;
            d_src   <= grant;
            d_valid <= 1'b1;
        end else if (d_ready) begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb2x1_reg.sv
// Directed and random checks of arb2x1_reg at 64-bit and 8-bit widths in lockstep,
// with a scoreboard of expected {src, data} results and a reference priority pointer.
module tb_arb2x1_reg;
    import arb2x1_reg_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        a_valid;
    logic        b_valid;
    logic        d_ready;

    logic        a_ready;
    logic        b_ready;
    logic [63:0] d;
    logic        d_src;
    logic        d_valid;

    logic        a_ready8;
    logic        b_ready8;
    logic [7:0]  d8;
    logic        d_src8;
    logic        d_valid8;

    logic [64:0] sbQueue[$];
    pri_e        modelPri;
    logic        lastAccA;
    logic        lastAccB;
    int          nAsserts = 0;
    int          nFails = 0;

    always #5 Clk = ~Clk;

    arb2x1_reg #(.DATAWIDTH(64)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b       (b),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .d       (d),
        .d_src   (d_src),
        .d_valid (d_valid),
        .d_ready (d_ready)
    );

    arb2x1_reg #(.DATAWIDTH(8)) dut8 (
        .Clk     (Clk),
        .Rst     (Rst),
        .a       (a[7:0]),
        .a_valid (a_valid),
        .a_ready (a_ready8),
        .b       (b[7:0]),
        .b_valid (b_valid),
        .b_ready (b_ready8),
        .d       (d8),
        .d_src   (d_src8),
        .d_valid (d_valid8),
        .d_ready (d_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic applyStimulus();
        logic g;
        logic ld;
        logic outXfer;
        #1;
        checkOutput("d_valid", 64'(d_valid), 64'(sbQueue.size() > 0));
        checkOutput("d_valid8", 64'(d_valid8), 64'(sbQueue.size() > 0));
        checkOutput("pri", 64'(dut.pri), 64'(modelPri));
        if (sbQueue.size() > 0) begin
            checkOutput("d", d, sbQueue[0][63:0]);
            checkOutput("d_src", 64'(d_src), 64'(sbQueue[0][64]));
            checkOutput("d8", 64'(d8), 64'(sbQueue[0][7:0]));
            checkOutput("d_src8", 64'(d_src8), 64'(sbQueue[0][64]));
        end
        if (a_valid && b_valid) g = (modelPri == PRI_B);
        else                    g = b_valid;
        ld      = (a_valid || b_valid) && ((sbQueue.size() == 0) || d_ready);
        outXfer = (sbQueue.size() > 0) && d_ready;
        checkOutput("a_ready", 64'(a_ready), 64'(ld && !g));
        checkOutput("b_ready", 64'(b_ready), 64'(ld && g));
        checkOutput("a_ready8", 64'(a_ready8), 64'(ld && !g));
        checkOutput("b_ready8", 64'(b_ready8), 64'(ld && g));
        lastAccA = ld && !g;
        lastAccB = ld && g;
        @(posedge Clk);
        if (outXfer) void'(sbQueue.pop_front());
        if (ld) begin
            sbQueue.push_back({g, g ? b : a});
            modelPri = g ? PRI_A : PRI_B;
        end
        @(negedge Clk);
    endtask

    initial begin
        Rst      = 1'b1;
        a        = '0;
        b        = '0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        d_ready  = 1'b0;
        modelPri = PRI_A;
        lastAccA = 1'b0;
        lastAccB = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("rst_d", d, 64'h0);
        checkOutput("rst_d_src", 64'(d_src), 64'h0);
        checkOutput("rst_d_valid", 64'(d_valid), 64'h0);
        checkOutput("rst_ready", 64'({a_ready, b_ready}), 64'h0);
        checkOutput("rst_pri", 64'(dut.pri), 64'(PRI_A));
        Rst = 1'b0;

        repeat (2) applyStimulus();
        checkOutput("idle_d", d, 64'h0);

        a = 64'h5; a_valid = 1'b1; d_ready = 1'b1;
        applyStimulus();
        a_valid = 1'b0;
        applyStimulus();

        a = 64'h11; b = 64'h22; a_valid = 1'b1; b_valid = 1'b1;
        repeat (6) applyStimulus();

        d_ready = 1'b0;
        repeat (3) applyStimulus();
        d_ready = 1'b1;
        repeat (3) applyStimulus();

        #2 Rst = 1'b1;
        #1;
        checkOutput("async_rst_d_valid", 64'(d_valid), 64'h0);
        checkOutput("async_rst_d", d, 64'h0);
        checkOutput("async_rst_pri", 64'(dut.pri), 64'(PRI_A));
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        checkOutput("async_rst_ready", 64'({a_ready, b_ready}), 64'h0);
        @(negedge Clk);
        Rst = 1'b0;
        sbQueue.delete();
        modelPri = PRI_A;
        lastAccA = 1'b0;
        lastAccB = 1'b0;

        a = 64'hFF; b = 64'h00;
        for (int i = 0; i < 200; i++) begin
            if (!a_valid || lastAccA) a_valid = 1'($urandom_range(0, 1));
            if (!b_valid || lastAccB) b_valid = 1'($urandom_range(0, 1));
            d_ready = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b1;
        repeat (2) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
